processador: RTL and testbench

PROCESSADOR -- requirements
Module: processador

---
 rtl/processador_if.sv | 14 +
 rtl/processador.sv | 149 ++++++++++++++
 tb/tb_processador.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/processador_if.sv
// Word-addressed port between the CPU and a synchronous single-port RAM.
// rdata returns one clock after addr; a store commits on the edge where we is high.
interface single_port_ram_port_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  we;

    modport cpu (output addr, output wdata, output we, input rdata);
    modport ram (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/processador.sv
// Multi-cycle 16-register CPU: FETCH, DECODE, EXECUTE, WRITEBACK, then back to FETCH.
// Latency is 4 cycles per instruction; there is no backpressure because the RAM always answers in one cycle.
module processador_banco_regs (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  raddr1_i,
    input  logic [3:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);
    logic [31:0] regs [0:15];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (we_i && (waddr_i != 4'd0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 4'd0) ? 32'd0 : regs[raddr1_i];
    assign rdata2_o = (raddr2_i == 4'd0) ? 32'd0 : regs[raddr2_i];
endmodule

module processador (
    input logic                  clock,
    input logic                  reset,
    single_port_ram_port_if.cpu  mem_port
);
    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      current_state;
    logic [15:0] PC;
    logic [31:0] instrucao_atual;
    logic [31:0] alu_q, alu_d;
    logic [15:0] pc_next_q, pc_next_d;

    logic [3:0]  opcode, rd, rs1, rs2;
    logic [15:0] imm;
    logic [31:0] imm_ext;
    logic [31:0] rs1_dat, rs2_dat;
    logic        is_mem_op;
    logic        rf_we;
    logic [31:0] rf_wdata;

    assign opcode  = instrucao_atual[31:28];
    assign rd      = instrucao_atual[27:24];
    assign rs1     = instrucao_atual[23:20];
    assign rs2     = instrucao_atual[19:16];
    assign imm     = instrucao_atual[15:0];
    assign imm_ext = {{16{imm[15]}}, imm};

    processador_banco_regs rb_inst (
        .clock_i  (clock),
        .reset_i  (reset),
        .we_i     (rf_we),
        .waddr_i  (rd),
        .wdata_i  (rf_wdata),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rs1_dat),
        .rdata2_o (rs2_dat)
    );

    always_comb begin
        alu_d = '0;
        case (opcode)
            OP_ADD:                alu_d = rs1_dat + rs2_dat;
            OP_SUB:                alu_d = rs1_dat - rs2_dat;
            OP_AND:                alu_d = rs1_dat & rs2_dat;
            OP_OR:                 alu_d = rs1_dat | rs2_dat;
            OP_XOR:                alu_d = rs1_dat ^ rs2_dat;
            OP_ADDI, OP_LW, OP_SW: alu_d = rs1_dat + imm_ext;
            default:               alu_d = '0;
        endcase
    end

    always_comb begin
        pc_next_d = PC + 16'd1;
        if ((opcode == OP_BEQ) && (rs1_dat == rs2_dat)) begin
            pc_next_d = PC + imm;
        end else if (opcode == OP_JMP) begin
            pc_next_d = imm;
        end
    end

    assign is_mem_op = (current_state == EXECUTE) && ((opcode == OP_LW) || (opcode == OP_SW));
    assign rf_we     = (current_state == WRITEBACK) && (opcode >= OP_ADD) && (opcode <= OP_LW);
    assign rf_wdata  = (opcode == OP_LW) ? mem_port.rdata : alu_q;

    // The store strobe is gated by reset so a reset landing in EXECUTE cannot commit the write.
    assign mem_port.addr  = is_mem_op ? alu_d[7:0] : PC[7:0];
    assign mem_port.wdata = rs2_dat;
    assign mem_port.we    = (current_state == EXECUTE) && (opcode == OP_SW) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            current_state   <= FETCH;
            PC              <= '0;
            instrucao_atual <= '0;
            alu_q           <= '0;
            pc_next_q       <= '0;
        end else begin
            case (current_state)
                FETCH: begin
                    current_state <= DECODE;
                end
                DECODE: begin
                    instrucao_atual <= mem_port.rdata;
                    current_state   <= EXECUTE;
                end
                EXECUTE: begin
                    if (opcode != OP_HALT) begin
                        alu_q         <= alu_d;
                        pc_next_q     <= pc_next_d;
                        current_state <= WRITEBACK;
                    end
                end
                WRITEBACK: begin
                    PC            <= pc_next_q;
                    current_state <= FETCH;
                end
                default: current_state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_processador.sv
// Scoreboarded bench for processador: expected fetch addresses and stores are queued
// by the stimulus; a negedge monitor pops and compares whenever the CPU fetches or writes.
module tb_processador;
    logic        clock;
    logic        reset;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_dat;
    logic        mon_en;
    logic [31:0] ram [0:255];
    int          total;
    int          bad;
    int          we_cnt;
    logic [15:0] fetch_q [$];
    logic [39:0] store_q [$];
    wire  [1:0]  st = dut.current_state;

    single_port_ram_port_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) mem_if ();

    processador dut (
        .clock    (clock),
        .reset    (reset),
        .mem_port (mem_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (load_en) begin
            ram[load_addr] <= load_dat;
        end else if (mem_if.we) begin
            ram[mem_if.addr] <= mem_if.wdata;
        end
        mem_if.rdata <= ram[mem_if.addr];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic note_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: unexpected event", nm);
    endtask

    // Monitor: every FETCH cycle and every store strobe is matched against the queues.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            if (st == 2'd0) begin
                if (fetch_q.size() == 0) note_fail("fetch_extra");
                else check("fetch_addr", {24'd0, mem_if.addr}, {16'd0, fetch_q.pop_front()});
            end
            if (mem_if.we) begin
                logic [39:0] e;
                we_cnt++;
                if (store_q.size() == 0) note_fail("store_extra");
                else begin
                    e = store_q.pop_front();
                    check("store_addr", {24'd0, mem_if.addr}, {24'd0, e[39:32]});
                    check("store_data", mem_if.wdata, e[31:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_dat  = d;
        tick(1);
        load_en   = 1'b0;
    endtask

    task automatic start_test();
        mon_en = 1'b0;
        reset  = 1'b1;
        fetch_q.delete();
        store_q.delete();
        tick(2);
        check("rst_pc", {16'd0, dut.PC}, 32'd0);
        check("rst_state", {30'd0, st}, 32'd0);
        for (int i = 0; i < 256; i++) poke(i[7:0], 32'd0);
    endtask

    task automatic go();
        we_cnt = 0;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic end_test(input string nm);
        check({nm, "_fetch_left"}, fetch_q.size(), 32'd0);
        check({nm, "_store_left"}, store_q.size(), 32'd0);
        mon_en = 1'b0;
    endtask

    task automatic push_fetches(input int first, input int last);
        for (int i = first; i <= last; i++) fetch_q.push_back(i[15:0]);
    endtask

    initial begin
        logic found;
        total = 0; bad = 0; we_cnt = 0;
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_dat = '0; mon_en = 1'b0;

        // Reset held for 5 cycles.
        tick(5);
        check("t0_pc", {16'd0, dut.PC}, 32'd0);
        check("t0_state", {30'd0, st}, 32'd0);
        check("t0_we", {31'd0, mem_if.we}, 32'd0);
        check("t0_instr", dut.instrucao_atual, 32'd0);
        for (int i = 0; i < 16; i++) check("t0_reg", dut.rb_inst.regs[i], 32'd0);

        // ALU program ending in HALT.
        start_test();
        poke(8'd0, 32'h6200_0007);
        poke(8'd1, 32'h1102_0000);
        poke(8'd2, 32'h2322_0000);
        poke(8'd3, 32'h4413_0000);
        poke(8'd4, 32'hF000_0000);
        push_fetches(0, 4);
        go();
        tick(40);
        check("t1_r1", dut.rb_inst.regs[1], 32'd7);
        check("t1_r3", dut.rb_inst.regs[3], 32'd0);
        check("t1_r4", dut.rb_inst.regs[4], 32'd7);
        check("t1_pc", {16'd0, dut.PC}, 32'h0004);
        check("t1_state", {30'd0, st}, 32'd2);
        end_test("t1");

        // Store then load of -1.
        start_test();
        poke(8'd0, 32'h6500_FFFF);
        poke(8'd1, 32'h8705_0010);
        poke(8'd2, 32'h7600_0010);
        poke(8'd3, 32'hF000_0000);
        push_fetches(0, 3);
        store_q.push_back({8'h10, 32'hFFFF_FFFF});
        go();
        tick(30);
        check("t2_mem10", ram[8'h10], 32'hFFFF_FFFF);
        check("t2_r6", dut.rb_inst.regs[6], 32'hFFFF_FFFF);
        check("t2_r7_untouched", dut.rb_inst.regs[7], 32'd0);
        check("t2_we_cycles", we_cnt, 32'd1);
        check("t2_pc", {16'd0, dut.PC}, 32'h0003);
        end_test("t2");

        // Overflow wrap, R0 write discard, logic ops, undefined opcode.
        start_test();
        poke(8'h20, 32'h7FFF_FFFF);
        poke(8'd0, 32'h7100_0020);
        poke(8'd1, 32'h6200_0001);
        poke(8'd2, 32'h1312_0000);
        poke(8'd3, 32'h1022_0000);
        poke(8'd4, 32'h6900_000C);
        poke(8'd5, 32'h6C00_0007);
        poke(8'd6, 32'h3AC9_0000);
        poke(8'd7, 32'h5BC9_0000);
        poke(8'd8, 32'h2D02_0000);
        poke(8'd9, 32'hCE12_0000);
        poke(8'd10, 32'hF000_0000);
        push_fetches(0, 10);
        go();
        tick(60);
        check("t3_r0", dut.rb_inst.regs[0], 32'd0);
        check("t3_r1", dut.rb_inst.regs[1], 32'h7FFF_FFFF);
        check("t3_r3", dut.rb_inst.regs[3], 32'h8000_0000);
        check("t3_and", dut.rb_inst.regs[10], 32'd4);
        check("t3_xor", dut.rb_inst.regs[11], 32'h0000_000B);
        check("t3_sub_wrap", dut.rb_inst.regs[13], 32'hFFFF_FFFF);
        check("t3_undef_nop", dut.rb_inst.regs[14], 32'd0);
        check("t3_pc", {16'd0, dut.PC}, 32'h000A);
        end_test("t3");

        // Branches: taken forward, not taken, jump, taken backward.
        start_test();
        poke(8'd0, 32'h6100_0005);
        poke(8'd4, 32'h9000_0002);
        poke(8'd5, 32'h6200_0009);
        poke(8'd6, 32'h9010_0004);
        poke(8'd7, 32'hA000_0020);
        poke(8'd8, 32'hF000_0000);
        poke(8'h20, 32'h9000_FFF0);
        poke(8'h10, 32'hF000_0000);
        push_fetches(0, 4);
        fetch_q.push_back(16'h0006);
        fetch_q.push_back(16'h0007);
        fetch_q.push_back(16'h0020);
        fetch_q.push_back(16'h0010);
        go();
        tick(50);
        check("t4_r1", dut.rb_inst.regs[1], 32'd5);
        check("t4_skipped", dut.rb_inst.regs[2], 32'd0);
        check("t4_pc", {16'd0, dut.PC}, 32'h0010);
        end_test("t4");

        // Unequal BEQ at PC 4, then reset during EXECUTE of a store.
        start_test();
        poke(8'd0, 32'h6100_0005);
        poke(8'd4, 32'h9010_0002);
        poke(8'd5, 32'h8001_0030);
        poke(8'd6, 32'hF000_0000);
        push_fetches(0, 5);
        go();
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick(1);
            if (st == 2'd2 && dut.instrucao_atual[31:28] == 4'h8) found = 1'b1;
        end
        if (!found) note_fail("t5_sw_timeout");
        check("t5_sw_pc", {16'd0, dut.PC}, 32'h0005);
        reset = 1'b1;
        tick(1);
        check("t5_pc", {16'd0, dut.PC}, 32'd0);
        check("t5_state", {30'd0, st}, 32'd0);
        check("t5_mem30", ram[8'h30], 32'd0);
        check("t5_we_cycles", we_cnt, 32'd0);
        end_test("t5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
